sm4_mode_ctrl: RTL

SM4_MODE_CTRL -- requirements
Module: sm4_mode_ctrl

---
 rtl/sm4_pkg.sv | 22 ++
 rtl/sm4_cbc_chain.sv | 50 +++++
 rtl/sm4_mode_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// Shared constants and types for the SM4 mode controller and its CBC chain.
// Block width, flush length, mode encoding and FSM state encoding live here.
package sm4_pkg;

  localparam int unsigned BLK_W     = 128;
  localparam int unsigned FLUSH_LEN = 40;
  localparam int unsigned FLUSH_W   = $clog2(FLUSH_LEN + 1);

  typedef enum logic {
    MODE_ECB = 1'b0,
    MODE_CBC = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEYX     = 3'd1,
    ST_RUN      = 3'd2,
    ST_CBC_WAIT = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

endpackage

// File: rtl/sm4_cbc_chain.sv
// CBC chaining registers and XOR muxing for the SM4 mode controller.
// Built only when SM4_CBC_EN is defined.
`ifdef SM4_CBC_EN
module sm4_cbc_chain
  import sm4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_iv,
  input  logic [BLK_W-1:0] iv,
  input  logic             encdec,
  input  logic [BLK_W-1:0] din,
  input  logic             in_fire,
  input  logic             out_fire,
  input  logic [BLK_W-1:0] core_bdo,
  output logic [BLK_W-1:0] bdi,
  output logic [BLK_W-1:0] dout
);

  logic [BLK_W-1:0] chain_q, chain_d;
  logic [BLK_W-1:0] next_q, next_d;

  always_comb begin
    chain_d = chain_q;
    next_d  = next_q;
    if (load_iv) begin
      chain_d = iv;
    end else if (out_fire) begin
      chain_d = encdec ? core_bdo : next_q;
    end
    // Decrypt chains on ciphertext, which must be held until its result returns.
    if (in_fire && !encdec) begin
      next_d = din;
    end
    bdi  = encdec ? (din ^ chain_q) : din;
    dout = encdec ? core_bdo : (core_bdo ^ chain_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      next_q  <= '0;
    end else begin
      chain_q <= chain_d;
      next_q  <= next_d;
    end
  end

endmodule
`endif

// File: rtl/sm4_mode_ctrl.sv
// Session controller sequencing an SM4 core through key expansion and ECB/CBC
// block streaming. CBC support is built only when SM4_CBC_EN is defined.
module sm4_mode_ctrl
  import sm4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic             encdec,
  input  logic [BLK_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic [15:0]      nblk,
  input  logic [BLK_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [BLK_W-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             core_en_sm4,
  output logic             core_encdec,
  output logic             core_en_key_exps,
  output logic             core_key_valid,
  output logic [BLK_W-1:0] core_key,
  input  logic             core_key_exps_done,
  output logic [BLK_W-1:0] core_bdi,
  output logic             core_bdi_valid,
  input  logic [BLK_W-1:0] core_bdo,
  input  logic             core_bdo_valid
);

  state_e             state_q, state_d;
  logic [15:0]        issued_q, issued_d;
  logic [15:0]        retired_q, retired_d;
  logic [15:0]        nblk_q, nblk_d;
  logic               encdec_q, encdec_d;
  logic [BLK_W-1:0]   key_q, key_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               en_sm4_q, en_sm4_d;
  logic               en_kx_q, en_kx_d;
  logic               key_valid_q, key_valid_d;

  logic               cbc;
  logic               load_iv;
  logic               in_fire;
  logic               out_ok;
  logic               out_fire;
  logic [BLK_W-1:0]   bdi_sel;
  logic [BLK_W-1:0]   dout_sel;

`ifdef SM4_CBC_EN
  logic             mode_q, mode_d;
  logic [BLK_W-1:0] chain_bdi;
  logic [BLK_W-1:0] chain_dout;

  sm4_cbc_chain u_chain (
    .clk      (clk),
    .rst      (rst),
    .load_iv  (load_iv),
    .iv       (iv),
    .encdec   (encdec_q),
    .din      (din),
    .in_fire  (in_fire),
    .out_fire (out_fire),
    .core_bdo (core_bdo),
    .bdi      (chain_bdi),
    .dout     (chain_dout)
  );

  assign cbc      = (mode_q == MODE_CBC);
  assign bdi_sel  = cbc ? chain_bdi : din;
  assign dout_sel = cbc ? chain_dout : core_bdo;
`else
  logic unused_cfg;

  assign cbc        = 1'b0;
  assign bdi_sel    = din;
  assign dout_sel   = core_bdo;
  assign unused_cfg = ^{mode, iv, load_iv};
`endif

  // Stream handshakes are combinational so ECB adds no latency in either direction.
  always_comb begin
    din_ready = (state_q == ST_RUN) && (issued_q < nblk_q) && !abort;
    in_fire   = din_ready && din_valid;
    if (cbc) begin
      out_ok = (state_q == ST_CBC_WAIT);
    end else begin
      out_ok = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (retired_q < nblk_q);
    end
    out_fire       = core_bdo_valid && out_ok && !abort;
    core_bdi_valid = in_fire;
    core_bdi       = in_fire ? bdi_sel : '0;
    dout_valid     = out_fire;
    dout           = out_fire ? dout_sel : '0;
  end

  always_comb begin
    state_d     = state_q;
    issued_d    = in_fire ? issued_q + 16'd1 : issued_q;
    retired_d   = out_fire ? retired_q + 16'd1 : retired_q;
    nblk_d      = nblk_q;
    encdec_d    = encdec_q;
    key_d       = key_q;
    flush_d     = (flush_q != '0) ? flush_q - FLUSH_W'(1) : flush_q;
    done_d      = 1'b0;
    en_sm4_d    = en_sm4_q;
    en_kx_d     = 1'b0;
    key_valid_d = 1'b0;
    load_iv     = 1'b0;
`ifdef SM4_CBC_EN
    mode_d      = mode_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && (flush_q == '0)) begin
          if (nblk == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_KEYX;
            nblk_d      = nblk;
            encdec_d    = encdec;
            key_d       = key;
            issued_d    = '0;
            retired_d   = '0;
            en_sm4_d    = 1'b1;
            en_kx_d     = 1'b1;
            key_valid_d = 1'b1;
            load_iv     = 1'b1;
`ifdef SM4_CBC_EN
            mode_d      = mode;
`endif
          end
        end
      end
      ST_KEYX: begin
        if (core_key_exps_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cbc && in_fire) begin
          state_d = ST_CBC_WAIT;
        end else if (issued_d == nblk_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_CBC_WAIT: begin
        if (out_fire) begin
          state_d = (retired_d == nblk_q) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (retired_q == nblk_q) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          en_sm4_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The core keeps emitting results after an abort; the flush window masks them.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      en_sm4_d    = 1'b0;
      en_kx_d     = 1'b0;
      key_valid_d = 1'b0;
      flush_d     = FLUSH_W'(FLUSH_LEN);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issued_q    <= '0;
      retired_q   <= '0;
      nblk_q      <= '0;
      encdec_q    <= 1'b0;
      key_q       <= '0;
      flush_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_sm4_q    <= 1'b0;
      en_kx_q     <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef SM4_CBC_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      nblk_q      <= nblk_d;
      encdec_q    <= encdec_d;
      key_q       <= key_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      en_sm4_q    <= en_sm4_d;
      en_kx_q     <= en_kx_d;
      key_valid_q <= key_valid_d;
`ifdef SM4_CBC_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign core_en_sm4      = en_sm4_q;
  assign core_en_key_exps = en_kx_q;
  assign core_key_valid   = key_valid_q;
  assign core_key         = key_q;
  assign core_encdec      = encdec_q;

endmodule
